// File: rtl/forward_scoreboard.sv
// ---------------------------------------------------------------------------
// forward_scoreboard
//
// Tracks the last DEPTH issued instructions (P[1] = youngest) and, for each
// source operand of the instruction waiting in decode, produces a forwarding
// mux select.  A select of 0 picks the register file, and a select of k picks
// stage P[k].  When a source depends on a load that is still too young to
// forward (k <= LOAD_LAT), STALL is raised and decode is held until the load
// reaches a forwardable stage.
//
// Optional feature (macro FWD_STATS_EN): adds the STALL_CNT output.  This is
// a 16-bit saturating count of stalled cycles.  FLUSH does not clear it.
//
// Parameters:
//   NUM_SRC   source operands checked per instruction (1..4)
//   DEPTH     tracked in-flight stages P[1..DEPTH] (2..4)
//   LOAD_LAT  stages after issue before load data is forwardable (1..DEPTH-1)
//   SELW      width of one select field
//
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   ISSUE_VALID      instruction requests to leave decode
//   ISSUE_RD         destination register of the issuing instruction
//   ISSUE_REGWRITE   issuing instruction writes RD
//   ISSUE_IS_LOAD    issuing instruction is a load
//   SRC_ADDR         source addresses, field i = [5i+4:5i]
//   SRC_USED         source i is read
//   SRC_FWD_EN       source i may take forwarded data
//   FLUSH            kill every tracked instruction
//   STALL            hold decode (combinational)
//   SEL              per-source select, field i = [SELW*i +: SELW]
//   STALL_CNT        stall statistics (FWD_STATS_EN only)
// ---------------------------------------------------------------------------
module forward_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ISSUE_VALID,
  input  logic [4:0]              ISSUE_RD,
  input  logic                    ISSUE_REGWRITE,
  input  logic                    ISSUE_IS_LOAD,
  input  logic [5*NUM_SRC-1:0]    SRC_ADDR,
  input  logic [NUM_SRC-1:0]      SRC_USED,
  input  logic [NUM_SRC-1:0]      SRC_FWD_EN,
  input  logic                    FLUSH,
  output logic                    STALL,
`ifdef FWD_STATS_EN
  output logic [SELW*NUM_SRC-1:0] SEL,
  output logic [15:0]             STALL_CNT
`else
  output logic [SELW*NUM_SRC-1:0] SEL
`endif
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] LDSTALL = 1'b1;

  logic [DEPTH:1]     valid_r;
  logic [DEPTH:1]     regwrite_r;
  logic [DEPTH:1]     is_load_r;
  logic [4:0]         rd_r [1:DEPTH];

  logic [0:0]         state_r;
  logic [0:0]         state_nxt_s;
  logic [SELW-1:0]    cnt_r;
  logic [SELW-1:0]    cnt_nxt_s;

  logic [SELW-1:0]    win_k_s [NUM_SRC];
  logic [NUM_SRC-1:0] win_load_s;
  logic               haz_s;
  logic [SELW-1:0]    haz_k_s;
  logic [SELW-1:0]    ld_val_s;
  logic               stall_s;
  logic               accept_s;

  // A stage can forward to a source only if it writes a real register
  // (x0 is hardwired) that the source actually reads and may bypass.
  function automatic logic src_hits(
    input logic       v,
    input logic       rw,
    input logic [4:0] rd,
    input logic [4:0] src,
    input logic       used,
    input logic       fwd
  );
    return v & rw & (rd != 5'd0) & (rd == src) & used & fwd;
  endfunction

  // Youngest-match search per source: scan oldest to youngest so the
  // smallest k overwrites any older hit.
  always_comb begin
    win_load_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_k_s[i] = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_hits(valid_r[k], regwrite_r[k], rd_r[k], SRC_ADDR[5*i +: 5],
                     SRC_USED[i], SRC_FWD_EN[i])) begin
          win_k_s[i]    = SELW'(k);
          win_load_s[i] = is_load_r[k];
        end else begin
          win_k_s[i]    = win_k_s[i];
          win_load_s[i] = win_load_s[i];
        end
      end
    end
  end

  // Load-use hazard: keep the youngest offending load, because it needs
  // the longest wait before it becomes forwardable.
  always_comb begin
    haz_s   = 1'b0;
    haz_k_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_load_s[i] && (win_k_s[i] != '0) &&
          (win_k_s[i] <= SELW'(LOAD_LAT)) &&
          (!haz_s || (win_k_s[i] < haz_k_s))) begin
        haz_s   = 1'b1;
        haz_k_s = win_k_s[i];
      end else begin
        haz_s   = haz_s;
        haz_k_s = haz_k_s;
      end
    end
  end

  // Extra wait cycles beyond the current one before the load can forward.
  assign ld_val_s = SELW'(LOAD_LAT) - haz_k_s;

  // Stall decision.  This path is not gated by FLUSH: a hazard seen in the
  // flush cycle still holds decode in that cycle.
  always_comb begin
    if (state_r == LDSTALL) begin
      stall_s = 1'b1;
    end else begin
      stall_s = ISSUE_VALID & haz_s;
    end
  end

  assign STALL    = stall_s;
  assign accept_s = ISSUE_VALID & ~stall_s & ~FLUSH;

  // Forwarding selects.  These are forced to the register file while decode
  // is held.
  always_comb begin
    SEL = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stall_s) begin
        SEL[SELW*i +: SELW] = '0;
      end else begin
        SEL[SELW*i +: SELW] = win_k_s[i];
      end
    end
  end

  // Next-state and stall-counter logic.  FLUSH overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (FLUSH) begin
      state_nxt_s = RUN;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (ISSUE_VALID && haz_s) begin
            cnt_nxt_s   = ld_val_s;
            state_nxt_s = (ld_val_s != '0) ? LDSTALL : RUN;
          end else begin
            cnt_nxt_s   = cnt_r;
            state_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          if (cnt_r <= SELW'(1)) begin
            cnt_nxt_s   = '0;
            state_nxt_s = RUN;
          end else begin
            cnt_nxt_s   = cnt_r - SELW'(1);
            state_nxt_s = LDSTALL;
          end
        end
        default: begin
          cnt_nxt_s   = '0;
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state and stall counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // In-flight pipe.  It shifts every cycle, and a bubble enters P[1]
  // whenever no issue is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_r    <= '0;
      regwrite_r <= '0;
      is_load_r  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= 5'd0;
      end
    end else begin
      if (FLUSH) begin
        valid_r <= '0;
      end else begin
        valid_r <= {valid_r[DEPTH-1:1], accept_s};
      end
      regwrite_r <= {regwrite_r[DEPTH-1:1], ISSUE_REGWRITE};
      is_load_r  <= {is_load_r[DEPTH-1:1], ISSUE_IS_LOAD};
      rd_r[1]    <= ISSUE_RD;
      for (int k = 2; k <= DEPTH; k++) begin
        rd_r[k] <= rd_r[k-1];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled cycles.  Only reset clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign STALL_CNT = stall_cnt_r;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_forward_scoreboard
//
// Two instances share one stimulus stream:
//   u_d2  defaults  (DEPTH=2, LOAD_LAT=1)
//   u_d4  DEPTH=4, LOAD_LAT=3
//
// Inputs are driven 1 ns after each rising edge, and the expected outputs
// for that cycle are queued at the same time.  A monitor on the falling
// edge pops the queue and compares the entries against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_forward_scoreboard;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       ISSUE_VALID;
  logic [4:0] ISSUE_RD;
  logic       ISSUE_REGWRITE;
  logic       ISSUE_IS_LOAD;
  logic [9:0] SRC_ADDR;
  logic [1:0] SRC_USED;
  logic [1:0] SRC_FWD_EN;
  logic       FLUSH;

  logic       stall2;
  logic       stall4;
  logic [3:0] sel2;
  logic [5:0] sel4;
`ifdef FWD_STATS_EN
  logic [15:0] cnt2;
  logic [15:0] cnt4;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        which;     // 0 = u_d2, 1 = u_d4
    logic        is_cnt;    // compare STALL_CNT instead of STALL/SEL
    logic        exp_stall;
    logic [7:0]  exp_sel;
    logic [15:0] exp_cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 CLK = ~CLK;

  forward_scoreboard u_d2 (
    .CLK(CLK), .RST_N(RST_N), .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .ISSUE_REGWRITE(ISSUE_REGWRITE), .ISSUE_IS_LOAD(ISSUE_IS_LOAD),
    .SRC_ADDR(SRC_ADDR), .SRC_USED(SRC_USED), .SRC_FWD_EN(SRC_FWD_EN),
    .FLUSH(FLUSH), .STALL(stall2),
`ifdef FWD_STATS_EN
    .SEL(sel2), .STALL_CNT(cnt2)
`else
    .SEL(sel2)
`endif
  );

  forward_scoreboard #(.NUM_SRC(2), .DEPTH(4), .LOAD_LAT(3)) u_d4 (
    .CLK(CLK), .RST_N(RST_N), .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .ISSUE_REGWRITE(ISSUE_REGWRITE), .ISSUE_IS_LOAD(ISSUE_IS_LOAD),
    .SRC_ADDR(SRC_ADDR), .SRC_USED(SRC_USED), .SRC_FWD_EN(SRC_FWD_EN),
    .FLUSH(FLUSH), .STALL(stall4),
`ifdef FWD_STATS_EN
    .SEL(sel4), .STALL_CNT(cnt4)
`else
    .SEL(sel4)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] u, input logic [1:0] f, input logic fl);
    ISSUE_VALID    = v;
    ISSUE_RD       = rd;
    ISSUE_REGWRITE = rw;
    ISSUE_IS_LOAD  = ld;
    SRC_ADDR       = {s1, s0};
    SRC_USED       = u;
    SRC_FWD_EN     = f;
    FLUSH          = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic expect_ss(input string nm, input logic w, input logic st,
                           input logic [7:0] sl);
    exp_t e;
    e.which     = w;
    e.is_cnt    = 1'b0;
    e.exp_stall = st;
    e.exp_sel   = sl;
    e.exp_cnt   = 16'd0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

`ifdef FWD_STATS_EN
  task automatic expect_cnt(input string nm, input logic w, input logic [15:0] c);
    exp_t e;
    e.which     = w;
    e.is_cnt    = 1'b1;
    e.exp_stall = 1'b0;
    e.exp_sel   = 8'd0;
    e.exp_cnt   = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
`endif

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t       e;
    string      nm;
    logic       act_stall;
    logic [7:0] act_sel;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.is_cnt) begin
`ifdef FWD_STATS_EN
          checks++;
          if ((e.which ? cnt4 : cnt2) !== e.exp_cnt) begin
            errors++;
            $display("FAIL %s: stall_cnt=%0d expected %0d", nm,
                     e.which ? cnt4 : cnt2, e.exp_cnt);
          end
`endif
        end else begin
          act_stall = e.which ? stall4 : stall2;
          act_sel   = e.which ? {2'b00, sel4} : {4'b0000, sel2};
          checks++;
          if (act_stall !== e.exp_stall) begin
            errors++;
            $display("FAIL %s: stall=%0b expected %0b", nm, act_stall, e.exp_stall);
          end
          checks++;
          if (act_sel !== e.exp_sel) begin
            errors++;
            $display("FAIL %s: sel=0x%0h expected 0x%0h", nm, act_sel, e.exp_sel);
          end
        end
      end
    end
  end

  initial begin
    idle();
    tick();
    // Reset state, with an issue request applied while RST_N is low.
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 5'd7, 2'b11, 2'b11, 1'b0);
    expect_ss("reset_d2", 1'b0, 1'b0, 8'h00);
    expect_ss("reset_d4", 1'b1, 1'b0, 8'h00);
`ifdef FWD_STATS_EN
    expect_cnt("reset_cnt_d2", 1'b0, 16'd0);
    expect_cnt("reset_cnt_d4", 1'b1, 16'd0);
`endif
    tick();
    RST_N = 1'b1;
    idle();

    // Load x7 followed by a dependent instruction.
    tick(); drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    expect_ss("load_issue_d2", 1'b0, 1'b0, 8'h00);
    expect_ss("load_issue_d4", 1'b1, 1'b0, 8'h00);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b0);
    expect_ss("lu_stall1_d4", 1'b1, 1'b1, 8'h00);
    expect_ss("lu_stall_d2", 1'b0, 1'b1, 8'h00);
    tick();
    expect_ss("lu_stall2_d4", 1'b1, 1'b1, 8'h00);
    expect_ss("lu_fwd_p2_d2", 1'b0, 1'b0, 8'h02);
    tick();
    expect_ss("lu_stall3_d4", 1'b1, 1'b1, 8'h00);
    tick();
    expect_ss("lu_fwd_p4_d4", 1'b1, 1'b0, 8'h04);
    tick(); idle();
`ifdef FWD_STATS_EN
    expect_cnt("stat_cnt_d4", 1'b1, 16'd3);
    expect_cnt("stat_cnt_d2", 1'b0, 16'd1);
`endif
    tick(); drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1);

    // Basic forwarding from P[1], then from P[2], then youngest-wins.
    tick(); drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    expect_ss("empty_pipe_d2", 1'b0, 1'b0, 8'h00);
`ifdef FWD_STATS_EN
    expect_cnt("cnt_kept_on_flush", 1'b1, 16'd3);
`endif
    tick(); drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01, 2'b11, 1'b0);
    expect_ss("fwd_p1_d2", 1'b0, 1'b0, 8'h01);
    expect_ss("fwd_p1_d4", 1'b1, 1'b0, 8'h01);
    tick(); drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    tick(); drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01, 2'b11, 1'b0);
    expect_ss("fwd_p2_d2", 1'b0, 1'b0, 8'h02);
    expect_ss("fwd_p2_d4", 1'b1, 1'b0, 8'h02);
    tick();
    expect_ss("fwd_p1_again_d2", 1'b0, 1'b0, 8'h01);
    tick(); drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11, 2'b11, 1'b0);
    expect_ss("youngest_wins_d2", 1'b0, 1'b0, 8'h05);
    expect_ss("youngest_wins_d4", 1'b1, 1'b0, 8'h09);

    // Store-data source with forwarding disabled, then unused and x0 sources.
    tick(); drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 2'b11, 2'b01, 1'b0);
    expect_ss("store_no_fwd_d2", 1'b0, 1'b0, 8'h01);
    expect_ss("store_no_fwd_d4", 1'b1, 1'b0, 8'h01);
    tick(); drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd5, 2'b10, 2'b11, 1'b0);
    expect_ss("unused_src_d2", 1'b0, 1'b0, 8'h00);
    expect_ss("unused_src_d4", 1'b1, 1'b0, 8'h00);
    tick(); drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b0);
    expect_ss("x0_src_d2", 1'b0, 1'b0, 8'h00);
    expect_ss("x0_src_d4", 1'b1, 1'b0, 8'h00);

    // FLUSH while u_d4 sits in LDSTALL.
    tick(); drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b0);
    expect_ss("ldstall_enter_d4", 1'b1, 1'b1, 8'h00);
    expect_ss("ld_stall_d2", 1'b0, 1'b1, 8'h00);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b1);
    expect_ss("flush_in_ldstall_d4", 1'b1, 1'b1, 8'h00);
    expect_ss("flush_cycle_sel_d2", 1'b0, 1'b0, 8'h02);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b0);
    expect_ss("after_flush_d4", 1'b1, 1'b0, 8'h00);
    expect_ss("after_flush_d2", 1'b0, 1'b0, 8'h00);

    // FLUSH in the same cycle as a newly detected hazard.
    tick(); drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b1);
    expect_ss("flush_hazard_d2", 1'b0, 1'b1, 8'h00);
    expect_ss("flush_hazard_d4", 1'b1, 1'b1, 8'h00);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b0);
    expect_ss("no_hazard_after_d2", 1'b0, 1'b0, 8'h00);
    expect_ss("no_hazard_after_d4", 1'b1, 1'b0, 8'h00);

    // Reset asserted in the middle of an LDSTALL.
    tick(); drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
    tick(); drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01, 2'b11, 1'b0);
    tick();
    expect_ss("ldstall_pre_reset_d4", 1'b1, 1'b1, 8'h00);
    tick();
    RST_N = 1'b0;
    expect_ss("async_reset_d4", 1'b1, 1'b0, 8'h00);
    expect_ss("async_reset_d2", 1'b0, 1'b0, 8'h00);
`ifdef FWD_STATS_EN
    expect_cnt("async_reset_cnt_d4", 1'b1, 16'd0);
`endif
    tick();
    RST_N = 1'b1;
    idle();
    expect_ss("post_reset_d4", 1'b1, 1'b0, 8'h00);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RST_N.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- NUM_SRC, 2, source operands checked per instruction; range 1..4.
- DEPTH, 2, tracked in-flight stages P[1..DEPTH]; range 2..4.
- LOAD_LAT, 1, stages after issue before load data is forwardable; range 1..DEPTH-1.
- SELW, $clog2(DEPTH+1), width of each select field.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1, clock, rising edge.
- RST_N, in, 1, asynchronous active-low reset.
- ISSUE_VALID, in, 1, an instruction requests to leave decode.
- ISSUE_RD, in, 5, destination register of the issuing instruction.
- ISSUE_REGWRITE, in, 1, the issuing instruction writes RD.
- ISSUE_IS_LOAD, in, 1, the issuing instruction is a load.
- SRC_ADDR, in, 5*NUM_SRC, source register addresses; field i = bits [5i+4:5i].
- SRC_USED, in, NUM_SRC, source i is read by the instruction.
- SRC_FWD_EN, in, NUM_SRC, source i may take forwarded data (0 for store data).
- FLUSH, in, 1, kill all tracked instructions.
- STALL, out, 1, hold decode; issue not accepted.
- SEL, out, SELW*NUM_SRC, per-source mux select; 0 = register file, k = stage P[k].
- STALL_CNT, out, 16, stall statistics (present only under FWD_STATS_EN).

Function
REQ-004 Each P[k] SHALL hold {valid, rd, regwrite, is_load}.
REQ-005 An issue SHALL be accepted when ISSUE_VALID=1 and STALL=0.
REQ-006 The pipe SHALL shift every cycle: P[k] <= P[k-1] for k>=2; P[1] <= accepted issue, otherwise a bubble (valid=0).
REQ-007 A source i SHALL match P[k] when: valid, regwrite, rd!=0, rd==SRC_ADDR[i], SRC_USED[i]=1 and SRC_FWD_EN[i]=1; the youngest (smallest k) match wins.
REQ-008 A load-use hazard SHALL exist when any source's winning match is a load with k<=LOAD_LAT.
REQ-009 The FSM SHALL have states RUN and LDSTALL.
REQ-010 In RUN with ISSUE_VALID=1 and a hazard at stage k, STALL SHALL assert combinationally in the same cycle, the stall counter SHALL load LOAD_LAT-k, and the FSM SHALL go to LDSTALL if that value is nonzero; otherwise it stays in RUN.
REQ-011 In LDSTALL, STALL SHALL be 1 and the counter SHALL decrement each cycle; the FSM SHALL return to RUN the cycle after the counter reads 1.
REQ-012 SEL SHALL be combinational from the current pipe and SRC inputs; while STALL=1, SEL SHALL be 0.
REQ-013 Unused or mask-disabled sources, and register x0, SHALL always yield SEL=0.
REQ-014 FLUSH SHALL have priority: on the next edge all valid bits clear, FSM goes to RUN, counter goes to 0, and no issue is accepted that cycle.
REQ-015 With simultaneous FLUSH and hazard, STALL SHALL still assert in the current cycle, and no hazard SHALL exist the following cycle.
REQ-016 A non-load match at any k, or a load match at k>LOAD_LAT, SHALL forward without stall.

Reset
REQ-017 While RST_N=0: all P[k].valid=0, FSM=RUN, counter=0, STALL=0, SEL=0, STALL_CNT=0.
REQ-018 Reset asserted mid-stall SHALL abandon the stall immediately (asynchronously).

Configuration
REQ-019 When macro FWD_STATS_EN is defined, STALL_CNT SHALL increment on every cycle with STALL=1 and RST_N=1, saturating at 16'hFFFF; FLUSH SHALL not clear it.
REQ-020 When FWD_STATS_EN is undefined, the STALL_CNT port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-021 Test: issue add x5, then next cycle issue with SRC0=x5 -> SEL0=1, STALL=0.
REQ-022 Test: issue x5, then a bubble, then issue reading x5 -> SEL0=2; with x5 also written by a newer issue in P[1] -> SEL0=1.
REQ-023 Test: load x7, then next cycle issue reading x7, LOAD_LAT=1 -> STALL=1 for exactly one cycle, then SEL0=2.
REQ-024 Test: LOAD_LAT=3, DEPTH=4, load x7 followed by a dependent instruction -> three stall cycles, then SEL=4; STALL_CNT=3 under FWD_STATS_EN.
REQ-025 Test: store with SRC1=x5 matching P[1], SRC_FWD_EN[1]=0 -> SEL1=0; any source x0 -> SEL=0.
REQ-026 Test: FLUSH during LDSTALL -> STALL=0 next cycle, pipe empty, SEL=0; RST_N low mid-stall -> STALL=0 immediately.
